// File: rtl/mem_port_arbiter_if.sv
// CPU, loader and memory-port signal bundle around the arbiter.
// slave = arbiter side, master = the surrounding CPU/loader/memory environment.
interface mem_port_arbiter_if;
    logic [31:0] cpu_mem_addr;
    logic [31:0] cpu_w_data;
    logic        cpu_wr_en;
    logic [31:0] cpu_r_data;

    logic        ldr_req;
    logic        ldr_we;
    logic [31:0] ldr_addr;
    logic [31:0] ldr_wdata;
    logic        ldr_ack;
    logic [31:0] ldr_rdata;

    logic [31:0] mem_addr;
    logic [31:0] mem_w_data;
    logic        mem_wr_en;
    logic [31:0] mem_r_data;

    modport slave (
        input  cpu_mem_addr, cpu_w_data, cpu_wr_en,
        output cpu_r_data,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_ack, ldr_rdata,
        output mem_addr, mem_w_data, mem_wr_en,
        input  mem_r_data
    );

    modport master (
        output cpu_mem_addr, cpu_w_data, cpu_wr_en,
        input  cpu_r_data,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_ack, ldr_rdata,
        input  mem_addr, mem_w_data, mem_wr_en,
        output mem_r_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin share of one sync-read memory port between CPU steps (3 clk each) and loader txns (4 clk).
// Backpressure: steps accumulate in a saturating counter while held/busy; the loader waits on ldr_ack.
module mem_port_arbiter #(
    parameter int CNT_W = 4
) (
    input  logic clk_100M,
    input  logic rst,
    input  logic step_en,
    input  logic cpu_hold,
    output logic cpu_clk_en,
    output logic step_ovf,
    mem_port_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] PEND_MAX = '1;
    localparam logic [CNT_W-1:0] PEND_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        CPU_SETUP,
        CPU_EXEC,
        LDR_SETUP,
        LDR_DATA,
        LDR_ACK
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] pend;
    logic             ovf_q;
    logic             last_grant_ldr;
    logic             ldr_ack_q;
    logic [31:0]      ldr_rdata_q;

    logic             cpu_cand;
    logic             ldr_cand;
    logic             grant_cpu;
    logic             grant_ldr;
    logic             pend_inc;
    logic             pend_dec;

    logic [31:0]      mem_addr_c;
    logic [31:0]      mem_w_data_c;
    logic             mem_wr_en_c;
    logic             cpu_clk_en_c;

    always_ff @(posedge clk_100M) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Round robin: on a tie the requester that was not served last wins.
    always_comb begin
        cpu_cand  = (pend != '0) && !cpu_hold;
        ldr_cand  = bus.ldr_req && !ldr_ack_q;
        grant_cpu = cpu_cand && (!ldr_cand || last_grant_ldr);
        grant_ldr = ldr_cand && !grant_cpu;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_cpu) begin
                    state_nxt = CPU_SETUP;
                end else if (grant_ldr) begin
                    state_nxt = LDR_SETUP;
                end
            end
            CPU_SETUP: state_nxt = CPU_EXEC;
            CPU_EXEC:  state_nxt = IDLE;
            LDR_SETUP: state_nxt = LDR_DATA;
            LDR_DATA:  state_nxt = LDR_ACK;
            LDR_ACK:   state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_addr_c   = bus.cpu_mem_addr;
        mem_w_data_c = bus.cpu_w_data;
        mem_wr_en_c  = 1'b0;
        cpu_clk_en_c = 1'b0;
        case (state)
            CPU_EXEC: begin
                mem_wr_en_c  = bus.cpu_wr_en;
                cpu_clk_en_c = 1'b1;
            end
            LDR_SETUP: begin
                mem_addr_c   = bus.ldr_addr;
                mem_w_data_c = bus.ldr_wdata;
                mem_wr_en_c  = bus.ldr_we;
            end
            LDR_DATA: begin
                mem_addr_c = bus.ldr_addr;
            end
            default: begin
            end
        endcase
    end

    // Reset masks the strobes combinationally so nothing commits while rst is low.
    assign cpu_clk_en     = cpu_clk_en_c && rst;
    assign bus.mem_wr_en  = mem_wr_en_c && rst;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.mem_w_data = mem_w_data_c;
    assign bus.cpu_r_data = bus.mem_r_data;
    assign bus.ldr_ack    = ldr_ack_q;
    assign bus.ldr_rdata  = ldr_rdata_q;
    assign step_ovf       = ovf_q;

    assign pend_inc = step_en;
    assign pend_dec = (state == CPU_EXEC) && (pend != '0);

    always_ff @(posedge clk_100M) begin
        if (!rst) begin
            pend  <= '0;
            ovf_q <= 1'b0;
        end else if (pend_inc && !pend_dec) begin
            if (pend == PEND_MAX) begin
                ovf_q <= 1'b1;
            end else begin
                pend <= pend + PEND_ONE;
            end
        end else if (pend_dec && !pend_inc) begin
            pend <= pend - PEND_ONE;
        end
    end

    always_ff @(posedge clk_100M) begin
        if (!rst) begin
            last_grant_ldr <= 1'b1;
            ldr_ack_q      <= 1'b0;
            ldr_rdata_q    <= '0;
        end else begin
            ldr_ack_q <= (state == LDR_DATA);
            if (state == CPU_EXEC) begin
                last_grant_ldr <= 1'b0;
            end else if (state == LDR_ACK) begin
                last_grant_ldr <= 1'b1;
            end
            if ((state == LDR_DATA) && !bus.ldr_we) begin
                ldr_rdata_q <= bus.mem_r_data;
            end
        end
    end

endmodule
